// File: rtl/cpu_instruction_cache_pkg.sv
// Shared definitions for the instruction cache: geometry, state encodings and
// the cache_line field positions that the pipeline also decodes.
package cpu_instruction_cache_pkg;

  localparam int ADDRESS_BITS   = 15;
  localparam int INDEX_BITS     = 6;
  localparam int OFFSET_BITS    = 2;
  localparam int TAG_BITS       = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int DATA_BITS      = 16;
  localparam int LINES          = 64;
  localparam int WORDS_PER_LINE = 4;

  localparam int LINE_ADDR_HI = 31;
  localparam int LINE_ADDR_LO = 17;
  localparam int LINE_HIT     = 16;
  localparam int LINE_DATA_HI = 15;
  localparam int LINE_DATA_LO = 0;

  typedef enum logic [1:0] {
    st_inval   = 2'd0,
    st_lookup  = 2'd1,
    st_fill    = 2'd2,
    st_refresh = 2'd3
  } state_t;

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDRESS_BITS-1:0] a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDRESS_BITS-1:0] a);
    return a[ADDRESS_BITS-1 -: TAG_BITS];
  endfunction

endpackage

// File: rtl/cpu_icache_bram.sv
// Data RAM (256x16) and tag/valid RAM (64x8), each with one synchronous read
// port and one write port so both map onto iCE40/ECP5 block RAM.
module cpu_icache_bram
  import cpu_instruction_cache_pkg::*;
(
  input  logic                              CLK,
  input  logic                              RSTb,
  input  logic [INDEX_BITS+OFFSET_BITS-1:0] data_rd_addr,
  output logic [DATA_BITS-1:0]              data_rd,
  input  logic                              data_we,
  input  logic [INDEX_BITS+OFFSET_BITS-1:0] data_wr_addr,
  input  logic [DATA_BITS-1:0]              data_wr_data,
  input  logic [INDEX_BITS-1:0]             tag_rd_addr,
  output logic [TAG_BITS:0]                 tag_rd,
  input  logic                              tag_we,
  input  logic [INDEX_BITS-1:0]             tag_wr_addr,
  input  logic [TAG_BITS:0]                 tag_wr_data
);

  logic [DATA_BITS-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_BITS:0]    tag_mem  [LINES];

  always_ff @(posedge CLK) begin
    if (data_we) data_mem[data_wr_addr] <= data_wr_data;
    if (tag_we)  tag_mem[tag_wr_addr]   <= tag_wr_data;
  end

  // Only the output registers are reset, so cache_line reads as zero in reset.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      data_rd <= '0;
      tag_rd  <= '0;
    end else begin
      data_rd <= data_mem[data_rd_addr];
      tag_rd  <= tag_mem[tag_rd_addr];
    end
  end

endmodule

// File: rtl/cpu_instruction_cache.sv
// Direct-mapped read-only instruction cache: lookup, 4-word line refill over a
// req/ack memory port, and a whole-cache invalidate sweep.
module cpu_instruction_cache
  import cpu_instruction_cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [14:0] cache_request_address,
  output logic [31:0] cache_line,
  output logic        cache_miss,
  output logic        mem_rd_req,
  output logic [14:0] mem_rd_addr,
  input  logic [15:0] mem_rd_data,
  input  logic        mem_rd_ack,
  input  logic        invalidate,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  state_t                            state;
  logic [ADDRESS_BITS-1:0]           address_r;
  logic [INDEX_BITS-1:0]             inval_idx;
  logic [OFFSET_BITS-1:0]            word_cnt;
  logic                              inval_pending;
  logic                              ram_fresh;
  logic [INDEX_BITS+OFFSET_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0]              data_rd;
  logic [TAG_BITS:0]                 tag_rd;
  logic                              data_we;
  logic [INDEX_BITS+OFFSET_BITS-1:0] data_wr_addr;
  logic                              tag_we;
  logic [INDEX_BITS-1:0]             tag_wr_addr;
  logic [TAG_BITS:0]                 tag_wr_data;
  logic                              last_word;

  // Memory port: mem_rd_req is the valid, mem_rd_ack the ready; a word transfers
  // on every edge where both are high, and mem_rd_addr holds until that edge.
  assign last_word    = (word_cnt == OFFSET_BITS'(WORDS_PER_LINE-1));
  assign data_we      = (state == st_fill) && mem_rd_ack;
  assign data_wr_addr = {addr_index(address_r), word_cnt};
  assign tag_we       = (state == st_inval) || (data_we && last_word);
  assign tag_wr_addr  = (state == st_inval) ? inval_idx : addr_index(address_r);
  assign tag_wr_data  = (state == st_inval) ? '0 : {1'b1, addr_tag(address_r)};

  assign rd_addr = (state == st_lookup) ? cache_request_address[INDEX_BITS+OFFSET_BITS-1:0]
                                        : address_r[INDEX_BITS+OFFSET_BITS-1:0];

  cpu_icache_bram u_bram (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .data_rd_addr (rd_addr),
    .data_rd      (data_rd),
    .data_we      (data_we),
    .data_wr_addr (data_wr_addr),
    .data_wr_data (mem_rd_data),
    .tag_rd_addr  (rd_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS]),
    .tag_rd       (tag_rd),
    .tag_we       (tag_we),
    .tag_wr_addr  (tag_wr_addr),
    .tag_wr_data  (tag_wr_data)
  );

  // ram_fresh guards the first lookup after a sweep, whose RAM read may predate
  // the final valid-bit clear.
  assign cache_miss = (state != st_lookup) || !ram_fresh || !tag_rd[TAG_BITS] ||
                      (tag_rd[TAG_BITS-1:0] != addr_tag(address_r));

  assign cache_line[LINE_ADDR_HI:LINE_ADDR_LO] = address_r;
  assign cache_line[LINE_HIT]                  = ~cache_miss;
  assign cache_line[LINE_DATA_HI:LINE_DATA_LO] = data_rd;
  assign busy      = (state != st_lookup);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state         <= st_inval;
      address_r     <= '0;
      inval_idx     <= '0;
      word_cnt      <= '0;
      inval_pending <= 1'b0;
      ram_fresh     <= 1'b0;
      mem_rd_req    <= 1'b0;
      mem_rd_addr   <= '0;
    end else begin
      ram_fresh <= (state == st_lookup) || (state == st_refresh);
      if (invalidate && (state != st_inval)) inval_pending <= 1'b1;
      case (state)
        st_inval: begin
          inval_idx <= inval_idx + 6'd1;
          if (inval_idx == INDEX_BITS'(LINES-1)) state <= st_lookup;
        end
        st_lookup: begin
          // address_r holds on a miss so the refresh re-reads the missing line.
          if (inval_pending) begin
            inval_pending <= 1'b0;
            inval_idx     <= '0;
            state         <= st_inval;
          end else if (cache_miss && ram_fresh) begin
            word_cnt    <= '0;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= {address_r[ADDRESS_BITS-1:OFFSET_BITS], 2'b00};
            state       <= st_fill;
          end else begin
            address_r <= cache_request_address;
          end
        end
        st_fill: begin
          if (mem_rd_ack) begin
            if (last_word) begin
              mem_rd_req <= 1'b0;
              state      <= st_refresh;
            end else begin
              word_cnt    <= word_cnt + 2'd1;
              mem_rd_addr <= mem_rd_addr + 15'd1;
            end
          end
        end
        st_refresh: state <= st_lookup;
        default:    state <= st_inval;
      endcase
    end
  end

endmodule
